// File: rtl/bcd_share_arb.sv
// Round-robin arbiter sharing one binary-to-BCD converter among NREQ requesters.
// The converted result sits in a single output register with valid/ready handshake.
module bcd_share_arb #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*10-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_val,
  output logic [3:0]         out_mod,
  output logic [IDW-1:0]     out_id,
  output logic [15:0]        conv_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [7:0]      val_q;
  logic [3:0]      mod_q;
  logic [IDW-1:0]  id_q;
  logic [15:0]     cnt_q;

  logic            slot_free;
  logic            grant_any;
  logic            grant;
  logic [IDW-1:0]  grant_idx;
  logic [9:0]      conv_in;
  logic [15:0]     conv_bcd;
  logic [7:0]      conv_val;
  logic [3:0]      conv_mod;

  // Double-dabble: 10-bit binary to four BCD digits.
  function automatic logic [15:0] bin2bcd(input logic [9:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    for (int i = 9; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

  assign slot_free = (state_q == StEmpty) || out_ready;

  // First valid requester at or above ptr, wrapping past NREQ-1.
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] cand;
    idx       = 0;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = idx[IDW-1:0];
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant     = grant_any && slot_free && !rst;
  assign req_ready = grant ? (NREQ'(1) << grant_idx) : '0;

  assign conv_in  = req_data[10*grant_idx +: 10];
  assign conv_bcd = bin2bcd(conv_in);
  assign conv_val = conv_bcd[7:0];
  // Thousands digit is only ever 1 for 1000..1023, where hundreds is 0.
  assign conv_mod = (conv_bcd[15:12] != 4'd0) ? 4'd10 : conv_bcd[11:8];

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StEmpty;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant) state_d = StFull;
      StFull:  if (out_ready && !grant) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state_q == StFull);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      val_q <= '0;
      mod_q <= '0;
      id_q  <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant) begin
        val_q <= conv_val;
        mod_q <= conv_mod;
        id_q  <= grant_idx;
      end
      if (out_valid && out_ready && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_val  = val_q;
  assign out_mod  = mod_q;
  assign out_id   = id_q;
  assign conv_cnt = cnt_q;

endmodule

// File: doc/bcd_share_arb.md
BCD_SHARE_ARB -- requirements
Module: bcd_share_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NREQ  4  number of requesters; legal values 2..8
  IDW  $clog2(NREQ)  width of out_id; derived, not overridden
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning (clock and reset first).
  clk  in  1  single clock; all state updates on the rising edge
  rst  in  1  synchronous, active-high reset
  req_valid  in  NREQ  per-requester request strobe
  req_data  in  NREQ*10  packed 10-bit binary operands; requester i uses bits [10*i+9 : 10*i]
  req_ready  out  NREQ  per-requester accept; one-hot or zero
  out_valid  out  1  result register holds a valid result
  out_ready  in  1  downstream accepts the result
  out_val  out  8  two BCD digits of (operand mod 100); tens digit in [7:4]
  out_mod  out  4  operand / 100, as binary 0..10
  out_id  out  IDW  index of the requester that produced the result
  conv_cnt  out  16  saturating count of delivered results
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-010 The block SHALL contain one instance of the shared combinational binary-to-BCD converter, with a 10-bit input and 8-bit/4-bit outputs.
REQ-011 The block SHALL register the converter output, with a latency of 1 cycle from the accept edge to out_valid=1.
REQ-012 A requester handshake SHALL complete on the edge where req_valid[i] and req_ready[i] are both 1. Requesters hold valid and data until that edge.
REQ-013 The slot SHALL be free when out_valid==0, or when out_valid==1 and out_ready==1 (drain and refill in the same cycle).
REQ-014 req_ready SHALL be combinational: only the arbitration winner is asserted, and only while the slot is free. req_ready SHALL be all-zero otherwise.
REQ-015 Arbitration SHALL be round-robin: the winner is the first requester with req_valid=1, searching upward from pointer ptr with wrap-around at NREQ-1 to 0.
REQ-016 After a grant to requester i, ptr SHALL become (i+1) mod NREQ. ptr SHALL be unchanged on cycles with no grant.
REQ-017 States SHALL be EMPTY and FULL.
  EMPTY to FULL on a grant.
  FULL to EMPTY on out_ready with no grant.
  FULL stays FULL on out_ready with a grant (new result loaded).
  FULL stays FULL on no out_ready (hold).
REQ-018 While FULL and out_ready==0, out_val, out_mod and out_id SHALL be stable.
REQ-019 Arithmetic SHALL satisfy out_mod = operand/100 and out_val = BCD(operand mod 100) for operands 0..1023. Operands 1000..1023 give out_mod = 10.
REQ-020 conv_cnt SHALL increment on each out_valid && out_ready edge and saturate at 16'hFFFF.
REQ-021 The design SHALL give 1 result per cycle of sustained throughput when out_ready is held at 1.
REQ-022 req_valid deasserted by a non-granted requester SHALL have no effect on the pointer or the state.

Reset
REQ-030 While rst=1, the next edge SHALL set: state=EMPTY, out_valid=0, out_val=0, out_mod=0, out_id=0, conv_cnt=0, ptr=0.
REQ-031 req_ready SHALL be 0 during any cycle with rst=1.
REQ-032 A result pending when reset arrives SHALL be discarded, with no conv_cnt increment.

Verification
REQ-040 Single conversion: req 0 with data 123, out_ready=1. Required: one cycle later out_valid=1, out_val=0x23, out_mod=1, out_id=0, then conv_cnt=1.
REQ-041 Boundaries: operands 0, 99, 100, 999, 1023. Required (out_mod, out_val): (0,0x00), (0,0x99), (1,0x00), (9,0x99), (10,0x23).
REQ-042 Round-robin: NREQ=4, all four valid continuously, out_ready=1. Required grant order 0,1,2,3,0,1, one grant per cycle.
REQ-043 Backpressure: out_ready=0 for 5 cycles with result 456 held. Required: out_val=0x56 and out_mod=4 stable, req_ready=0, no new grant. Then out_ready=1 drains and refills in the same cycle.
REQ-044 Reset mid-operation: assert rst while FULL. Required: out_valid=0, conv_cnt=0, ptr=0 next edge; the first grant after reset goes to the lowest valid index.
REQ-045 Saturation: preload conv_cnt near the limit via 65535 transfers (forced). Required: the count holds at 16'hFFFF on further transfers.
